// File: rtl/weight_sram_reader_if.sv
// Output word stream of the weight SRAM reader (valid/ready with last marker).
interface weight_sram_reader_if #(
  parameter int DATA_W = 512
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/weight_sram_reader.sv
// Read-side master for the weight SRAM: streams a contiguous address range
// out in order through a 2-entry buffer, absorbing the SRAM's 1-cycle read
// latency and consumer backpressure. Never writes the SRAM.
module weight_sram_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 512,
  parameter int DEPTH  = 1728
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sram_csb,
  output logic              sram_wsb,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  weight_sram_reader_if.master strm
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W-1:0]   r_issued;
  logic [ADDR_W-1:0]   r_rcvd;
  logic [ADDR_W-1:0]   r_raddr;
  logic                r_inflight;
  logic                r_done;
  logic                r_err;

  // Two-entry output buffer: r_head is the word presented to the consumer.
  logic [1:0]          r_cnt;
  logic [DATA_W-1:0]   r_head;
  logic [DATA_W-1:0]   r_tail;
  logic                r_head_last;
  logic                r_tail_last;

  logic                w_pop;
  logic                w_push;
  logic                w_push_last;
  logic                w_issue;
  logic [2:0]          w_occ;
  logic [2:0]          w_lim;
  logic [ADDR_W-1:0]   w_addr;
  logic [ADDR_W:0]     w_end;
  logic                w_oob;

  assign w_pop       = (r_cnt != 2'd0) && strm.out_ready;
  assign w_push      = r_inflight;
  assign w_push_last = (r_rcvd == r_len - 1'b1);
  assign w_addr      = r_base + r_issued;

  // Buffered words plus the read in flight must leave room for one more,
  // counting a word leaving this cycle as freed space.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign w_lim   = 3'd2 + {2'b00, w_pop};
  assign w_issue = (r_state == S_RUN) && (r_issued < r_len) && (w_occ < w_lim);

  // Range check one bit wider so base+len cannot wrap.
  assign w_end = {1'b0, base_addr} + {1'b0, len};
  assign w_oob = w_end > (ADDR_W+1)'(DEPTH);

  assign sram_csb   = ~w_issue;
  assign sram_wsb   = 1'b1;
  assign sram_raddr = w_issue ? w_addr : r_raddr;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign err  = r_err;

  assign strm.out_valid = (r_cnt != 2'd0);
  assign strm.out_data  = r_head;
  assign strm.out_last  = r_head_last && (r_cnt != 2'd0);

  // Command FSM: accept/reject commands, issue reads, detect completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_rcvd     <= '0;
      r_raddr    <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_raddr  <= w_addr;
        r_issued <= r_issued + 1'b1;
      end
      if (w_push) r_rcvd <= r_rcvd + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_done <= 1'b1;
            end else if (w_oob) begin
              r_err <= 1'b1;
            end else begin
              r_base   <= base_addr;
              r_len    <= len;
              r_issued <= '0;
              r_rcvd   <= '0;
              r_state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_issue && (r_issued == r_len - 1'b1)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && strm.out_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output buffer: capture read data the cycle after issue, shift on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 2'd0;
      r_head      <= '0;
      r_tail      <= '0;
      r_head_last <= 1'b0;
      r_tail_last <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head      <= sram_rdata;
            r_head_last <= w_push_last;
          end else begin
            r_head      <= r_tail;
            r_head_last <= r_tail_last;
            r_tail      <= sram_rdata;
            r_tail_last <= w_push_last;
          end
        end
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_head      <= sram_rdata;
            r_head_last <= w_push_last;
          end else begin
            r_tail      <= sram_rdata;
            r_tail_last <= w_push_last;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd2) begin
            r_head      <= r_tail;
            r_head_last <= r_tail_last;
          end
          r_cnt <= r_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_sram_reader.sv
// Bench for weight_sram_reader: SRAM model with registered read, command
// runner collecting observations, and per-scenario checks against a model.
module tb_weight_sram_reader;
  localparam int AW = 11, DW = 512, DEPTH = 1728;

  logic clk = 0, rst = 1, start = 0;
  logic [AW-1:0] base_addr = '0, len = '0;
  logic busy, done, err, sram_csb, sram_wsb;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata = '0;

  weight_sram_reader_if #(.DATA_W(DW)) strm();

  weight_sram_reader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .err(err), .sram_csb(sram_csb), .sram_wsb(sram_wsb),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .strm(strm)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] wexp(input int i);
    logic [31:0] v;
    v = i;
    return {16{v}};
  endfunction

  // SRAM model: word i = {16{i}}, data valid the cycle after csb=0, junk otherwise.
  always @(posedge clk)
    sram_rdata <= (!sram_csb) ? wexp(int'(sram_raddr)) : {16{32'hDEADBEEF}};

  int wsb_bad = 0;
  always @(negedge clk) if (sram_wsb !== 1'b1) wsb_bad++;

  int total = 0, bad = 0;
  logic [DW-1:0] got_q[$];
  bit last_q[$];
  int csb_n, acc_n, done_n, err_n, first_v_n, stall_bad, ovr_bad, addr_bad;
  bit busy_end, prev_stall;
  logic [DW-1:0] prev_data;
  logic [5:0] pat = 6'b011001;

  // Drive one command and record what the DUT does until done/err or budget.
  task automatic run_cmd(input logic [AW-1:0] b, input logic [AW-1:0] l,
                         input int rmode, input int maxc, input bit poke);
    got_q.delete(); last_q.delete();
    csb_n = 0; acc_n = 0; done_n = -1; err_n = -1; first_v_n = -1;
    stall_bad = 0; ovr_bad = 0; addr_bad = 0; busy_end = 1; prev_stall = 0;
    @(posedge clk); #1;
    start = 1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 0;
    for (int n = 0; n < maxc; n++) begin
      case (rmode)
        0: strm.out_ready = 1'b1;
        1: strm.out_ready = pat[n % 6];
        default: strm.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      start = poke && (n == 3 || n == 4);
      if (poke) begin base_addr = 11'd7; len = 11'd2; end
      #1;
      if (prev_stall && (!strm.out_valid || strm.out_data !== prev_data)) stall_bad++;
      if (!sram_csb) begin
        if (int'(sram_raddr) != int'(b) + csb_n) addr_bad++;
        csb_n++;
      end
      if (strm.out_valid && first_v_n < 0) first_v_n = n;
      if (strm.out_valid && strm.out_ready) begin
        got_q.push_back(strm.out_data);
        last_q.push_back(strm.out_last);
        acc_n++;
      end
      if (csb_n - acc_n > 2) ovr_bad++;
      prev_stall = strm.out_valid && !strm.out_ready;
      prev_data  = strm.out_data;
      if (done || err) begin
        if (done) done_n = n;
        if (err) err_n = n;
        busy_end = busy;
        break;
      end
      @(posedge clk); #1;
    end
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1; strm.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 0 || done !== 0 || err !== 0) begin bad++;
      $display("FAIL reset_status busy=%b done=%b err=%b exp 0 0 0", busy, done, err); end
    total++; if (sram_csb !== 1 || sram_wsb !== 1 || sram_raddr !== '0) begin bad++;
      $display("FAIL reset_sram csb=%b wsb=%b raddr=%0d exp 1 1 0", sram_csb, sram_wsb, sram_raddr); end
    total++; if (strm.out_valid !== 0 || strm.out_last !== 0 || strm.out_data !== '0) begin bad++;
      $display("FAIL reset_stream valid=%b last=%b data=%h exp 0 0 0", strm.out_valid, strm.out_last, strm.out_data[31:0]); end
    rst = 0;
  endtask

  task automatic test_basic();
    int wb = 0;
    run_cmd(11'd5, 11'd4, 0, 40, 0);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== wexp(5 + i) || last_q[i] !== (i == 3)) wb++;
    total++; if (wb != 0) begin bad++; $display("FAIL basic_words bad_words=%0d exp=0", wb); end
    total++; if (first_v_n != 2) begin bad++; $display("FAIL basic_first_valid got=%0d exp=2", first_v_n); end
    total++; if (done_n != 6) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=6", done_n); end
    total++; if (csb_n != 4) begin bad++; $display("FAIL basic_reads got=%0d exp=4", csb_n); end
    total++; if (busy_end !== 0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", busy_end); end
  endtask

  task automatic test_backpressure();
    int wb = 0;
    run_cmd(11'd100, 11'd6, 1, 200, 0);
    total++; if (got_q.size() != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== wexp(100 + i) || last_q[i] !== (i == 5)) wb++;
    total++; if (wb != 0) begin bad++; $display("FAIL bp_words bad_words=%0d exp=0", wb); end
    total++; if (stall_bad != 0 || ovr_bad != 0) begin bad++;
      $display("FAIL bp_protocol stall_bad=%0d overissue=%0d exp 0 0", stall_bad, ovr_bad); end
    total++; if (done_n < 0 || addr_bad != 0) begin bad++;
      $display("FAIL bp_done done_n=%0d addr_bad=%0d", done_n, addr_bad); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int b, l, wb;
      b = $urandom_range(0, 1700); l = $urandom_range(1, 24); wb = 0;
      run_cmd(AW'(b), AW'(l), 2, 400, 0);
      for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== wexp(b + i) || last_q[i] !== (i == l - 1)) wb++;
      total++; if (got_q.size() != l || wb != 0 || done_n < 0) begin bad++;
        $display("FAIL rand_stream base=%0d len=%0d got=%0d bad_words=%0d done_n=%0d", b, l, got_q.size(), wb, done_n); end
      total++; if (stall_bad != 0 || ovr_bad != 0 || addr_bad != 0 || csb_n != l) begin bad++;
        $display("FAIL rand_protocol stall=%0d over=%0d addr=%0d reads=%0d exp_reads=%0d", stall_bad, ovr_bad, addr_bad, csb_n, l); end
    end
  endtask

  task automatic test_boundary();
    int wb = 0;
    run_cmd(11'd1720, 11'd8, 0, 40, 0);
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== wexp(1720 + i) || last_q[i] !== (i == 7)) wb++;
    total++; if (got_q.size() != 8 || wb != 0) begin bad++;
      $display("FAIL edge_words got=%0d bad_words=%0d exp 8 0", got_q.size(), wb); end
    total++; if (done_n != 10 || csb_n != 8) begin bad++;
      $display("FAIL edge_done done_n=%0d reads=%0d exp 10 8", done_n, csb_n); end
    run_cmd(11'd1721, 11'd8, 0, 10, 0);
    total++; if (err_n != 0 || done_n != -1 || csb_n != 0 || busy_end !== 0) begin bad++;
      $display("FAIL oob_err err_n=%0d done_n=%0d reads=%0d busy=%b exp 0 -1 0 0", err_n, done_n, csb_n, busy_end); end
    run_cmd(11'd33, 11'd0, 0, 10, 0);
    total++; if (done_n != 0 || err_n != -1 || csb_n != 0 || got_q.size() != 0) begin bad++;
      $display("FAIL len0 done_n=%0d err_n=%0d reads=%0d words=%0d exp 0 -1 0 0", done_n, err_n, csb_n, got_q.size()); end
  endtask

  task automatic test_full();
    int wb = 0;
    run_cmd(11'd0, 11'd1728, 0, 2000, 0);
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== wexp(i) || last_q[i] !== (i == 1727)) wb++;
    total++; if (got_q.size() != 1728 || wb != 0) begin bad++;
      $display("FAIL full_words got=%0d bad_words=%0d exp 1728 0", got_q.size(), wb); end
    total++; if (done_n != 1730) begin bad++; $display("FAIL full_done_cycle got=%0d exp=1730", done_n); end
    total++; if (wsb_bad != 0) begin bad++; $display("FAIL wsb_low count=%0d exp=0", wsb_bad); end
  endtask

  task automatic test_start_busy();
    int wb = 0;
    run_cmd(11'd200, 11'd10, 2, 400, 1);
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== wexp(200 + i) || last_q[i] !== (i == 9)) wb++;
    total++; if (got_q.size() != 10 || wb != 0 || csb_n != 10 || addr_bad != 0 || done_n < 0) begin bad++;
      $display("FAIL start_busy got=%0d bad_words=%0d reads=%0d addr_bad=%0d done_n=%0d", got_q.size(), wb, csb_n, addr_bad, done_n); end
  endtask

  task automatic test_reset_mid();
    int acc = 0, reads = 0, dn = 0;
    bit hit = 0;
    @(posedge clk); #1;
    start = 1; base_addr = 11'd400; len = 11'd10;
    @(posedge clk); #1;
    start = 0; strm.out_ready = 1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (strm.out_valid && strm.out_ready) acc++;
      if (acc == 3) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    total++; if (!hit) begin bad++; $display("FAIL rstmid_reach accepted=%0d exp=3", acc); end
    rst = 1;
    @(posedge clk); #1;
    total++; if (busy !== 0 || done !== 0 || sram_csb !== 1 || sram_raddr !== '0 ||
                 strm.out_valid !== 0 || strm.out_data !== '0 || strm.out_last !== 0) begin bad++;
      $display("FAIL rstmid_outputs busy=%b done=%b csb=%b raddr=%0d valid=%b last=%b", busy, done, sram_csb, sram_raddr, strm.out_valid, strm.out_last); end
    rst = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (!sram_csb) reads++;
      if (done) dn++;
    end
    total++; if (reads != 0 || dn != 0) begin bad++;
      $display("FAIL rstmid_quiet reads=%0d done=%0d exp 0 0", reads, dn); end
  endtask

  task automatic test_after_reset();
    int wb = 0;
    run_cmd(11'd50, 11'd5, 2, 200, 0);
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== wexp(50 + i) || last_q[i] !== (i == 4)) wb++;
    total++; if (got_q.size() != 5 || wb != 0 || done_n < 0) begin bad++;
      $display("FAIL after_reset got=%0d bad_words=%0d done_n=%0d", got_q.size(), wb, done_n); end
  endtask

  initial begin
    strm.out_ready = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_boundary();
    test_full();
    test_start_busy();
    test_reset_mid();
    test_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/weight_sram_reader.md
Name: weight_sram_reader

Overview:
- Read-side master for the 1728x512b weight SRAM.
- On a start command it reads a contiguous address range through the SRAM's chip-select/read port and accounts for the SRAM's 1-cycle registered read latency.
- It streams the words out in address order on a valid/ready interface with a 2-entry output buffer, so backpressure from the consumer (PE array weight loader) never loses or duplicates a word.
- It never writes the SRAM.

Parameters:
ADDR_W, 11, SRAM address width
DATA_W, 512, SRAM word width
DEPTH, 1728, number of SRAM words (legal addresses 0..DEPTH-1)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  command pulse; sampled only when busy=0
base_addr  in  ADDR_W  first word address of command
len  in  ADDR_W  number of words to read (0..DEPTH)
busy  out  1  command in progress
done  out  1  1-cycle pulse at command completion
err  out  1  1-cycle pulse when command rejected
sram_csb  out  1  SRAM chip enable, active low
sram_wsb  out  1  SRAM write enable, active low; constant 1
sram_raddr  out  ADDR_W  SRAM read address
sram_rdata  in  DATA_W  SRAM read data, valid the cycle after csb=0
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts word
out_data  out  DATA_W  output word
out_last  out  1  marks final word of command, qualified by out_valid

Behaviour:
- Reset values: busy=0, done=0, err=0, sram_csb=1, sram_wsb=1, sram_raddr=0, out_valid=0, out_data=0, out_last=0. Also cleared: FSM=IDLE, issue counter, in-flight flag, buffer count.
- Reset mid-command aborts immediately. Buffered words and any in-flight read are discarded. No done pulse.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: when start=1:
  - If len=0: done pulses next cycle, no reads, stay IDLE.
  - Else if base_addr+len > DEPTH (compare at ADDR_W+1 bits): err pulses next cycle, no reads, stay IDLE.
  - Else: latch base_addr/len, busy=1, go to RUN.
- start while busy=1 is ignored. No queuing.
- RUN issue rule: drive sram_csb=0 and sram_raddr=base+issued when issued<len and (buf_count + inflight - pop) < 2. pop = out_valid & out_ready this cycle. Otherwise sram_csb=1 and sram_raddr holds.
  - Issued read sets inflight for the next cycle.
  - When the last address is issued, go to DRAIN.
- Capture: on the cycle after an issue (inflight=1), sram_rdata is written into the 2-entry FIFO at the posedge ending that cycle.
- The FIFO never overflows by construction. Simultaneous push and pop is allowed and leaves the count unchanged.
- Output: out_valid = FIFO non-empty. out_data = head entry, registered, stable while out_valid=1 and out_ready=0.
- out_last=1 exactly on the word whose index is len-1.
- DRAIN: no issues. When the last word handshakes (out_valid&out_ready&out_last), go to IDLE next edge: busy=0 and done=1 for that one cycle.
- A new start is accepted in the cycle busy=0 (the same cycle done=1).
- Latency: start accepted at edge E0. First csb=0 in cycle after E0. First out_valid=1 after E0+2.
- Throughput: with out_ready held 1, one word per cycle, so len words complete in len+2 cycles after E0. done is high in the cycle after the final handshake.
- Address arithmetic: sram_raddr = base + issued, no wrap; the range check guarantees addr ≤ DEPTH-1.
- sram_wsb is tied to 1 in every state, including reset.

Test Plan:
- Basic stream: preload mem[i]={16{i[31:0]}} for i=0..1727; start base=5 len=4, out_ready=1 → out_data words 5,6,7,8 on 4 consecutive cycles starting E0+2; out_last only on 8; done pulse one cycle after; exactly 4 csb=0 cycles; wsb never 0.
- Backpressure: base=100 len=6, out_ready toggling 1,0,0,1,1,0,… → words 100..105 in order, no loss/duplicate; out_data stable while stalled; csb=0 never when buffer+inflight=2.
- Boundary range: base=1720 len=8 → reads 1720..1727, done. base=1721 len=8 → err pulse, no csb=0, busy stays 0. len=0 → done pulse only.
- Full memory: base=0 len=1728, out_ready=1 → 1728 words, last word index 1727 with out_last, total 1730 cycles from E0 to done.
- Start while busy plus reset mid-operation: start again during command → ignored, sequence unchanged. Assert rst at word 3 of len=10 → next cycle all outputs at reset values, no further csb=0, no done. A new command after reset streams correctly from its base.
